voq_buffer: RTL and testbench
=============================

VOQ_BUFFER -- requirements
Module: voq_buffer

Interface
REQ-001 Parameter NUMBER_PORTS, default 4: number of switch output ports, and number of virtual output queues (VOQs).
REQ-002 Parameter DATA_WIDTH, default 32: width of one buffered cell.
REQ-003 Parameter QUEUE_DEPTH, default 4: cells per VOQ; SHALL be a power of two, at least 2.
REQ-004 Define DW = $clog2(NUMBER_PORTS).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  offered cell valid.
REQ-008 in_ready  output  1  VOQ selected by in_dest can accept a cell.
REQ-009 in_data  input  DATA_WIDTH  offered cell payload.
REQ-010 in_dest  input  DW  destination output port of offered cell.
REQ-011 request  output  NUMBER_PORTS  bit k = VOQ k non-empty; feeds one row of the scheduler request matrix.
REQ-012 grant_valid  input  1  scheduler grant valid this cycle.
REQ-013 grant_dest  input  DW  output port granted to this input.
REQ-014 out_valid  output  1  dequeued cell valid, toward crossbar.
REQ-015 out_data  output  DATA_WIDTH  dequeued cell payload.
REQ-016 out_dest  output  DW  destination of dequeued cell.

Function
REQ-017 Each VOQ k SHALL be a circular buffer with write pointer, read pointer (both wrapping modulo QUEUE_DEPTH) and occupancy count 0..QUEUE_DEPTH.
REQ-018 in_ready SHALL be combinational: 1 iff count[in_dest] < QUEUE_DEPTH; independent of in_valid and of the current cycle's grant.
REQ-019 Push: when in_valid && in_ready, in_data SHALL be written at wptr[in_dest]; wptr increments and count increments at the edge.
REQ-020 request[k] SHALL be driven from registered state (count[k] != 0); a push into an empty VOQ raises request[k] the cycle after the push edge.
REQ-021 Pop: when grant_valid && count[grant_dest] != 0, the head cell SHALL be registered onto out_data/out_dest with out_valid=1 at the next edge; rptr increments and count decrements.
REQ-022 Grant to an empty VOQ SHALL be ignored: no pointer change, out_valid=0 next cycle.
REQ-023 out_valid SHALL be 1 for exactly one cycle per pop; with no pop, out_valid=0, and out_data/out_dest hold their last values.
REQ-024 Latency: grant edge to out_valid is 1 cycle; push edge to request visible is 1 cycle.
REQ-025 Simultaneous push and pop on the same non-empty VOQ SHALL both occur; count is unchanged, and the popped cell is the old head.
REQ-026 Simultaneous push and grant on the same empty VOQ: the push occurs, the grant is ignored (no bypass).
REQ-027 Full VOQ with a same-cycle grant: in_ready stays 0 that cycle (no pop-through).
REQ-028 Push and pop on different VOQs in the same cycle SHALL proceed independently.
REQ-029 FIFO order SHALL be preserved per VOQ across pointer wrap-around.
REQ-030 Out-of-range grant_dest or in_dest (>= NUMBER_PORTS) SHALL be ignored, with in_ready=0.

Reset
REQ-031 While reset=1, all pointers and counts SHALL clear to 0; request=0, out_valid=0, out_data=0, out_dest=0.
REQ-032 Reset SHALL take priority over a same-cycle push or grant; cells in flight are discarded.
REQ-033 In the first cycle after reset deasserts, in_ready=1 for every valid in_dest.

Verification
REQ-034 Push 0xA5A5A5A5 to dest 2 → next cycle request=4'b0100; grant dest 2 → next cycle out_valid=1, out_data=0xA5A5A5A5, out_dest=2, request=0.
REQ-035 Push 4 cells (1,2,3,4) to dest 1 → in_ready=0 with in_dest=1, in_ready=1 with in_dest=0; 6 pops yield 1,2,3,4, then two cycles of out_valid=0.
REQ-036 Continuous push and pop on dest 3 for 10 cycles (values 0..9) → outputs in order 0..9 with no loss across wrap.
REQ-037 Grant dest 0 while VOQ 0 is empty and a same-cycle push to dest 0 → out_valid=0, then request[0]=1 next cycle.
REQ-038 Fill VOQ 0 with 2 cells, assert reset for one cycle mid-grant → out_valid=0, request=0, in_ready=1 after reset.

Source files
------------

// File: rtl/voq_buffer.sv
// Input-port buffer for a crossbar switch: one circular FIFO (VOQ) per output port.
// Pushes are steered by in_dest; pops are driven by the scheduler grant and registered toward the crossbar.
module voq_buffer #(
  parameter int unsigned NUMBER_PORTS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned QUEUE_DEPTH  = 4,
  localparam int unsigned DW = (NUMBER_PORTS > 1) ? $clog2(NUMBER_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DW-1:0]           in_dest,
  output logic [NUMBER_PORTS-1:0] request,
  input  logic                    grant_valid,
  input  logic [DW-1:0]           grant_dest,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DW-1:0]           out_dest
);

  localparam int unsigned AW         = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam bit          FULL_RANGE = (NUMBER_PORTS == (1 << DW));

  logic [DATA_WIDTH-1:0]   mem   [NUMBER_PORTS][QUEUE_DEPTH];
  logic [AW-1:0]           wptr  [NUMBER_PORTS];
  logic [AW-1:0]           rptr  [NUMBER_PORTS];
  logic [CW-1:0]           count [NUMBER_PORTS];

  logic                    in_range;
  logic                    grant_range;
  logic [DW-1:0]           in_idx;
  logic [DW-1:0]           grant_idx;
  logic                    push;
  logic                    pop;
  logic [NUMBER_PORTS-1:0] push_vec;
  logic [NUMBER_PORTS-1:0] pop_vec;

  // Destinations beyond NUMBER_PORTS only exist when the port count is not a power of two.
  generate
    if (FULL_RANGE) begin : g_full_range
      assign in_range    = 1'b1;
      assign grant_range = 1'b1;
    end else begin : g_part_range
      assign in_range    = (32'(in_dest) < NUMBER_PORTS);
      assign grant_range = (32'(grant_dest) < NUMBER_PORTS);
    end
  endgenerate

  assign in_idx    = in_range ? in_dest : '0;
  assign grant_idx = grant_range ? grant_dest : '0;

  // Acceptance looks only at registered occupancy, so a full VOQ never pops through.
  assign in_ready = in_range && (count[in_idx] != CW'(QUEUE_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = grant_valid && grant_range && (count[grant_idx] != '0);

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    request  = '0;
    if (push) push_vec[in_idx] = 1'b1;
    if (pop) pop_vec[grant_idx] = 1'b1;
    for (int k = 0; k < int'(NUMBER_PORTS); k++) begin
      request[k] = (count[k] != '0);
    end
  end

  // Per-VOQ pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUMBER_PORTS); k++) begin
        wptr[k]  <= '0;
        rptr[k]  <= '0;
        count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUMBER_PORTS); k++) begin
        if (push_vec[k]) wptr[k] <= wptr[k] + AW'(1);
        if (pop_vec[k]) rptr[k] <= rptr[k] + AW'(1);
        case ({push_vec[k], pop_vec[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // Cell storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[in_idx][wptr[in_idx]] <= in_data;
  end

  // Registered dequeue port; data and destination hold between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= mem[grant_idx][rptr[grant_idx]];
        out_dest <= grant_dest;
      end
    end
  end

endmodule

// File: tb/tb_voq_buffer.sv
// Self-checking bench for voq_buffer: per-VOQ reference queues feed a per-cycle scoreboard
// that is compared against the registered outputs on every falling edge.
`timescale 1ns/1ps
module tb_voq_buffer;

  localparam int unsigned NP    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DWID  = 32;

  typedef struct {
    bit              valid;
    logic [DWID-1:0] data;
    logic [1:0]      dest;
    logic [NP-1:0]   req;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DWID-1:0] in_data = '0;
  logic [1:0]      in_dest = '0;
  logic [NP-1:0]   request;
  logic            grant_valid = 1'b0;
  logic [1:0]      grant_dest = '0;
  logic            out_valid;
  logic [DWID-1:0] out_data;
  logic [1:0]      out_dest;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  logic [DWID-1:0] mq [NP][$];
  exp_t            sb_q [$];
  bit              m_valid = 1'b0;
  logic [DWID-1:0] m_data = '0;
  logic [1:0]      m_dest = '0;

  voq_buffer #(.NUMBER_PORTS(NP), .DATA_WIDTH(DWID), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .request(request), .grant_valid(grant_valid), .grant_dest(grant_dest),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] model_req();
    logic [NP-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NP); k++) r[k] = (mq[k].size() != 0);
    return r;
  endfunction

  // One clock of stimulus; the reference model advances and queues what the DUT must show next.
  task automatic drive(input bit v, input logic [DWID-1:0] d, input logic [1:0] dst,
                       input bit gv, input logic [1:0] gd);
    bit   do_push;
    bit   do_pop;
    exp_t e;
    in_valid = v; in_data = d; in_dest = dst; grant_valid = gv; grant_dest = gd;
    do_push = v && (mq[dst].size() < DEPTH);
    do_pop  = gv && (mq[gd].size() != 0);
    @(posedge clk);
    if (do_pop) begin
      m_data = mq[gd].pop_front();
      m_dest = gd;
    end
    if (do_push) mq[dst].push_back(d);
    m_valid = do_pop;
    e.valid = m_valid; e.data = m_data; e.dest = m_dest; e.req = model_req();
    sb_q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    @(posedge clk);
    for (int k = 0; k < int'(NP); k++) mq[k].delete();
    m_valid = 1'b0; m_data = '0; m_dest = '0;
    e.valid = 1'b0; e.data = '0; e.dest = '0; e.req = '0;
    sb_q.push_back(e);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; grant_valid = 1'b0;
    do_reset();
    do_reset();
    checks++;
    if (request !== 4'b0000 || out_valid !== 1'b0 || out_data !== '0 || out_dest !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b ov=%b od=%h odst=%0d, need req=0000 ov=0 od=0 odst=0",
               request, out_valid, out_data, out_dest);
    end
    for (int d = 0; d < int'(NP); d++) begin
      in_dest = 2'(d);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready dest=%0d: got %b need 1", d, in_ready);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 32'hA5A5A5A5, 2'd2, 1'b0, 2'd0);
    checks++;
    if (request !== 4'b0100) begin
      errors++;
      $display("FAIL single_request: got %b need 0100", request);
    end
    drive(1'b0, '0, 2'd0, 1'b1, 2'd2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_dest !== 2'd2 || request !== 4'b0000) begin
      errors++;
      $display("FAIL single_pop: ov=%b od=%h odst=%0d req=%b need 1 a5a5a5a5 2 0000",
               out_valid, out_data, out_dest, request);
    end
    idle(1);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) drive(1'b1, DWID'(i), 2'd1, 1'b0, 2'd0);
    in_valid = 1'b0; in_dest = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full_ready: got %b need 0", in_ready);
    end
    in_dest = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_other_ready: got %b need 1", in_ready);
    end
    // Two extra grants against the drained queue must produce nothing.
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 2'd0, 1'b1, 2'd1);
  endtask

  task automatic test_full_grant();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + DWID'(i), 2'd0, 1'b0, 2'd0);
    in_valid = 1'b1; in_data = 32'hDEAD; in_dest = 2'd0; grant_valid = 1'b1; grant_dest = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_grant_ready: got %b need 0", in_ready);
    end
    drive(1'b1, 32'hDEAD, 2'd0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 2'd0, 1'b1, 2'd0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) drive(1'b1, DWID'(i), 2'd3, 1'b1, 2'd3);
    for (int i = 0; i < 2; i++) drive(1'b0, '0, 2'd0, 1'b1, 2'd3);
    checks++;
    if (request !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_drained: req=%b need 0000", request);
    end
  endtask

  task automatic test_collide();
    drive(1'b1, 32'h77, 2'd0, 1'b1, 2'd0);
    checks++;
    if (out_valid !== 1'b0 || request[0] !== 1'b1) begin
      errors++;
      $display("FAIL collide_empty: ov=%b req0=%b need ov=0 req0=1", out_valid, request[0]);
    end
    drive(1'b0, '0, 2'd0, 1'b1, 2'd0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h2222, 2'd2, 1'b0, 2'd0);
    drive(1'b1, 32'h1111, 2'd1, 1'b1, 2'd2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2222 || request !== 4'b0010) begin
      errors++;
      $display("FAIL independent: ov=%b od=%h req=%b need 1 2222 0010", out_valid, out_data, request);
    end
    drive(1'b1, 32'h3333, 2'd1, 1'b1, 2'd1);
    drive(1'b0, '0, 2'd0, 1'b1, 2'd1);
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hAA, 2'd0, 1'b0, 2'd0);
    drive(1'b1, 32'hBB, 2'd0, 1'b0, 2'd0);
    in_valid = 1'b1; in_data = 32'hCC; in_dest = 2'd0; grant_valid = 1'b1; grant_dest = 2'd0;
    do_reset();
    in_valid = 1'b0; in_dest = 2'd0; grant_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || request !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: ov=%b req=%b rdy=%b need 0 0000 1", out_valid, request, in_ready);
    end
    drive(1'b0, '0, 2'd0, 1'b1, 2'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 2'd0, 1'b1, 2'(i % 4));
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_fill();
        test_full_grant();
        test_wrap();
        test_collide();
        test_back_to_back();
        test_reset_mid();
        test_random();
        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
        end
        done = 1'b1;
      end
      begin
        // Output monitor: one scoreboard entry per driven clock.
        while (!done) begin
          @(negedge clk);
          if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== e.valid || out_data !== e.data || out_dest !== e.dest || request !== e.req) begin
              errors++;
              $display("FAIL monitor t=%0t: ov=%b od=%h odst=%0d req=%b need ov=%b od=%h odst=%0d req=%b",
                       $time, out_valid, out_data, out_dest, request, e.valid, e.data, e.dest, e.req);
            end
          end
        end
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
